z80fi_ld_a_ir_checker: RTL
==========================

Name: z80fi_ld_a_ir_checker

Overview:
- Sequential formal-interface checker for the pair LD A,I (ED 57) and LD A,R (ED 5F).
- Watches the retirement stream and compares each decoded instruction's results against a golden model.
- Tracks R-register continuity across all retirements.
- Optionally models the NMOS IFF2 quirk: P/V reads 0 if an interrupt is accepted right after the instruction, which forces a one-retirement deferred verdict.
- Sits beside the per-instruction spec modules in the z80fi harness and drives assertions and a saturating error counter.

Parameters:
CHECK_I, 1, enable checking of LD A,I
CHECK_R, 1, enable checking of LD A,R
NMOS_IFF2_QUIRK, 0, 1 = resolve P/V using the following retirement
R_TRACK, 1, enable R continuity check across every retirement
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
z80fi_valid  in  1  one instruction retires this cycle
z80fi_int_ack  in  1  qualifies z80fi_valid: the retirement is an interrupt acknowledge, not an instruction
z80fi_insn  in  32  instruction bytes, first byte in [7:0]
z80fi_insn_len  in  3  instruction length in bytes
z80fi_reg_a_out  in  8  A after retirement
z80fi_reg_f_in  in  8  F before
z80fi_reg_f_out  in  8  F after
z80fi_reg_i_in  in  8  I before
z80fi_reg_r_in  in  8  R before
z80fi_reg_r_out  in  8  R after
z80fi_reg_iff2_in  in  1  IFF2 before
z80fi_reg_ip_in  in  16  PC before
z80fi_reg_ip_out  in  16  PC after
chk_valid  out  1  one-cycle pulse: a verdict is presented
chk_ok  out  1  verdict passed; meaningful only with chk_valid
chk_err  out  6  failure mask: [0] A, [1] F except P/V, [2] P/V, [3] IP, [4] R result, [5] R continuity
err_count  out  ERR_CNT_W  saturating count of failed verdicts

Behaviour:
- Reset: clocking and reset are fixed as one clock, `clk`, with asynchronous, active-high `reset`. Asserting reset (async) clears chk_valid=0, chk_ok=0, chk_err=0, err_count=0, state=IDLE and r_shadow_valid=0. Any pending verdict is discarded and no pulse is emitted.
- Decode: match needs z80fi_valid=1, int_ack=0, len=2, insn[15:0]=16'h57ED (I) or 16'h5FED (R), with the matching CHECK_* parameter set.
- Source value: for LD A,I, src = I_in. For LD A,R, src = R_exp = {R_in[7], R_in[6:0]+2 mod 128}. Bit 7 is preserved; the low 7 bits wrap from 7F to 01.
- Expected results:
  - A_out = src.
  - F_out = (F_in & 0x29) | S=src[7] | Z=(src==0) | PV. H and N are 0.
  - R_out = R_exp for both instructions.
  - IP_out = IP_in + 2, mod 2^16.
- P/V expectation: IFF2_in when NMOS_IFF2_QUIRK=0. With the quirk, it is IFF2_in if the next retirement is not int_ack, and 0 if it is.
- FSM, non-quirk:
  - IDLE only.
  - A match registers its verdict, and chk_valid pulses exactly 1 cycle after the retirement cycle.
- FSM, quirk:
  - IDLE, match → PEND. All checks except P/V are computed and latched; the captured F_out[2] and IFF2 are held.
  - PEND, next z80fi_valid → verdict pulse 1 cycle later, with P/V resolved by the int_ack rule.
  - If that retirement is itself a match, its checks are latched and the state stays in PEND (back-to-back).
  - Otherwise PEND → IDLE.
- R continuity (R_TRACK=1):
  - On every z80fi_valid, including int_ack, r_shadow ← R_out and r_shadow_valid ← 1.
  - If r_shadow_valid and R_in ≠ r_shadow, set err bit 5.
  - A continuity error on a non-matching retirement emits its own verdict pulse, 1 cycle later. In quirk PEND it merges into the pending verdict.
- Verdict arithmetic: chk_ok = (chk_err==0). err_count increments by 1 per failed verdict and saturates at 2^ERR_CNT_W−1.
- At most one verdict per cycle. Reset in the same cycle as a retirement wins.

Decomposition:
- The shared z80fi package holds the flag bit constants (S, Z, 5, H, 3, PV, N, C) and the opcode constants for ED 57 and ED 5F.
- It also holds an enum for the chk_err bit positions and the FSM state enum.
- One sub-module, z80fi_r_tracker: r_shadow register, valid bit, and continuity compare. It is reusable by other checkers.

Test Plan:
1. LD A,I with I=0x80, IFF2=1, F_in=0xFF, IP=0x1234; DUT A=0x80, F=0xAD, IP=0x1236 → chk_valid at +1 cycle, chk_ok=1, err_count=0.
2. LD A,R with R_in=0xFF; DUT R_out=0x81, A=0x81 → ok. Repeat with DUT A=0x01 → chk_err=6'b000001, err_count=1.
3. Quirk=1: LD A,I with IFF2=1, DUT F PV=0, next retirement int_ack → verdict pulse 1 cycle after int_ack, ok. The same trace followed by NOP instead → chk_err[2]=1.
4. Quirk=1: two back-to-back LD A,R retirements, then NOP → two verdicts, one per following retirement; state IDLE at the end.
5. R_TRACK: NOP with R_out=0x05, then NOP with R_in=0x06 → chk_err=6'b100000. Reset asserted while in PEND → no pulse, and err_count returns to 0.
6. ERR_CNT_W=2: drive 5 failing LD A,I retirements → err_count sticks at 3.

Source files
------------

// File: rtl/z80fi_ld_a_ir_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_ld_a_ir_checker_pkg
// Description : Shared constants and types for the LD A,I / LD A,R checker.
// Revision    : 1.0 - initial release
// ============================================================================
package z80fi_ld_a_ir_checker_pkg;

    localparam int unsigned c_FLAG_C  = 0;
    localparam int unsigned c_FLAG_N  = 1;
    localparam int unsigned c_FLAG_PV = 2;
    localparam int unsigned c_FLAG_3  = 3;
    localparam int unsigned c_FLAG_H  = 4;
    localparam int unsigned c_FLAG_5  = 5;
    localparam int unsigned c_FLAG_Z  = 6;
    localparam int unsigned c_FLAG_S  = 7;

    // Flags carried through unchanged from F_in: bits 5, 3 and C.
    localparam logic [7:0]  c_F_COPY_MASK = 8'h29;

    localparam logic [15:0] c_OP_LD_A_I   = 16'h57ED;
    localparam logic [15:0] c_OP_LD_A_R   = 16'h5FED;
    localparam logic [2:0]  c_LD_A_IR_LEN = 3'd2;

    typedef enum logic [2:0] {
        ERR_BIT_A      = 3'd0,
        ERR_BIT_F      = 3'd1,
        ERR_BIT_PV     = 3'd2,
        ERR_BIT_IP     = 3'd3,
        ERR_BIT_R_RES  = 3'd4,
        ERR_BIT_R_CONT = 3'd5
    } chk_err_bit_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } chk_state_e;

    // R after an ED-prefixed instruction: bit 7 held, low 7 bits advance by 2.
    function automatic logic [7:0] r_after_ed(input logic [7:0] r);
        return {r[7], r[6:0] + 7'd2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/z80fi_r_tracker.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_r_tracker
// Description : Shadows R across retirements and flags any R_in discontinuity.
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_r_tracker
    import z80fi_ld_a_ir_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_r_in,
    input  logic [7:0] i_r_out,
    output logic       o_cont_err
);

    logic [7:0] r_shadow;
    logic       r_shadow_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow       <= 8'h00;
            r_shadow_valid <= 1'b0;
        end else if (i_valid) begin
            r_shadow       <= i_r_out;
            r_shadow_valid <= 1'b1;
        end
    end

    assign o_cont_err = i_valid && r_shadow_valid && (i_r_in != r_shadow);

endmodule
`default_nettype wire

// File: rtl/z80fi_ld_a_ir_checker.sv
`default_nettype none
// ============================================================================
// Module      : z80fi_ld_a_ir_checker
// Description : Golden-model checker for LD A,I / LD A,R on the z80fi stream.
// Revision    : 1.0 - initial release
// ============================================================================
module z80fi_ld_a_ir_checker
    import z80fi_ld_a_ir_checker_pkg::*;
#(
    parameter int CHECK_I         = 1,
    parameter int CHECK_R         = 1,
    parameter int NMOS_IFF2_QUIRK = 0,
    parameter int R_TRACK         = 1,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 z80fi_valid,
    input  logic                 z80fi_int_ack,
    input  logic [31:0]          z80fi_insn,
    input  logic [2:0]           z80fi_insn_len,
    input  logic [7:0]           z80fi_reg_a_out,
    input  logic [7:0]           z80fi_reg_f_in,
    input  logic [7:0]           z80fi_reg_f_out,
    input  logic [7:0]           z80fi_reg_i_in,
    input  logic [7:0]           z80fi_reg_r_in,
    input  logic [7:0]           z80fi_reg_r_out,
    input  logic                 z80fi_reg_iff2_in,
    input  logic [15:0]          z80fi_reg_ip_in,
    input  logic [15:0]          z80fi_reg_ip_out,
    output logic                 chk_valid,
    output logic                 chk_ok,
    output logic [5:0]           chk_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam bit c_QUIRK = (NMOS_IFF2_QUIRK != 0);

    logic                 w_base, w_is_i, w_is_r, w_match;
    logic [7:0]           w_r_exp, w_src, w_f_exp, w_f_out_nopv;
    logic [5:0]           w_insn_err, w_verdict;
    logic                 w_cont_err, w_emit, w_pend_load;
    logic                 w_unused_insn_hi;

    chk_state_e           r_state;
    logic [5:0]           r_pend_err;
    logic                 r_pend_pv_out, r_pend_iff2;
    logic                 r_chk_valid, r_chk_ok;
    logic [5:0]           r_chk_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    assign w_unused_insn_hi = ^z80fi_insn[31:16];

    assign w_base  = z80fi_valid && !z80fi_int_ack && (z80fi_insn_len == c_LD_A_IR_LEN);
    assign w_is_i  = w_base && (z80fi_insn[15:0] == c_OP_LD_A_I) && (CHECK_I != 0);
    assign w_is_r  = w_base && (z80fi_insn[15:0] == c_OP_LD_A_R) && (CHECK_R != 0);
    assign w_match = w_is_i || w_is_r;

    assign w_r_exp = r_after_ed(z80fi_reg_r_in);
    assign w_src   = w_is_i ? z80fi_reg_i_in : w_r_exp;

    // Expected F with P/V left at 0; P/V is judged separately.
    always_comb begin
        w_f_exp               = z80fi_reg_f_in & c_F_COPY_MASK;
        w_f_exp[c_FLAG_S]     = w_src[7];
        w_f_exp[c_FLAG_Z]     = (w_src == 8'h00);
        w_f_out_nopv          = z80fi_reg_f_out;
        w_f_out_nopv[c_FLAG_PV] = 1'b0;
    end

    always_comb begin
        w_insn_err                 = 6'b000000;
        w_insn_err[ERR_BIT_A]      = (z80fi_reg_a_out != w_src);
        w_insn_err[ERR_BIT_F]      = (w_f_out_nopv != w_f_exp);
        w_insn_err[ERR_BIT_PV]     = (z80fi_reg_f_out[c_FLAG_PV] != z80fi_reg_iff2_in);
        w_insn_err[ERR_BIT_IP]     = (z80fi_reg_ip_out != (z80fi_reg_ip_in + 16'd2));
        w_insn_err[ERR_BIT_R_RES]  = (z80fi_reg_r_out != w_r_exp);
    end

    generate
        if (R_TRACK != 0) begin : g_r_track
            z80fi_r_tracker u_r_tracker (
                .clk        (clk),
                .reset      (reset),
                .i_valid    (z80fi_valid),
                .i_r_in     (z80fi_reg_r_in),
                .i_r_out    (z80fi_reg_r_out),
                .o_cont_err (w_cont_err)
            );
        end else begin : g_no_r_track
            assign w_cont_err = 1'b0;
        end
    endgenerate

    assign w_pend_load = c_QUIRK && w_match;

    // A pending quirk verdict is resolved by whatever retires next; a match
    // retiring in that slot keeps its own continuity result for its own verdict.
    always_comb begin
        w_emit    = 1'b0;
        w_verdict = 6'b000000;
        if (r_state == ST_PEND) begin
            if (z80fi_valid) begin
                w_emit                 = 1'b1;
                w_verdict              = r_pend_err;
                w_verdict[ERR_BIT_PV]  = (r_pend_pv_out != (r_pend_iff2 && !z80fi_int_ack));
                if (!w_match) begin
                    w_verdict[ERR_BIT_R_CONT] = r_pend_err[ERR_BIT_R_CONT] | w_cont_err;
                end
            end
        end else if (!w_pend_load && (w_match || w_cont_err)) begin
            w_emit                    = 1'b1;
            w_verdict                 = w_match ? w_insn_err : 6'b000000;
            w_verdict[ERR_BIT_R_CONT] = w_cont_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pend_err    <= 6'b000000;
            r_pend_pv_out <= 1'b0;
            r_pend_iff2   <= 1'b0;
            r_chk_valid   <= 1'b0;
            r_chk_ok      <= 1'b0;
            r_chk_err     <= 6'b000000;
            r_err_count   <= '0;
        end else begin
            r_chk_valid <= w_emit;
            if (w_emit) begin
                r_chk_err <= w_verdict;
                r_chk_ok  <= (w_verdict == 6'b000000);
                if ((w_verdict != 6'b000000) && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
            end
            if (w_pend_load) begin
                r_state                     <= ST_PEND;
                r_pend_err                  <= w_insn_err;
                r_pend_err[ERR_BIT_PV]      <= 1'b0;
                r_pend_err[ERR_BIT_R_CONT]  <= w_cont_err;
                r_pend_pv_out               <= z80fi_reg_f_out[c_FLAG_PV];
                r_pend_iff2                 <= z80fi_reg_iff2_in;
            end else if ((r_state == ST_PEND) && z80fi_valid) begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign chk_valid = r_chk_valid;
    assign chk_ok    = r_chk_ok;
    assign chk_err   = r_chk_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
